// File: rtl/score_matrix_engine.sv
// Score-matrix engine: S = Q x K^T over row-major Q/K in the result SRAM.
// Each S element is written to the scratchpad at SCRATCH_BASE + i*N + j.
module score_matrix_engine #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 16,
  parameter int MAX_DIM      = 64,
  parameter int SCRATCH_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dut_valid,
  output logic              dut_ready,
  input  logic [15:0]       seq_len,
  input  logic [15:0]       head_dim,
  output logic              dim_error,
  output logic [ADDR_W-1:0] dut__tb__sram_result_read_address,
  input  logic [DATA_W-1:0] tb__dut__sram_result_read_data,
  output logic              dut__tb__sram_scratchpad_write_enable,
  output logic [ADDR_W-1:0] dut__tb__sram_scratchpad_write_address,
  output logic [DATA_W-1:0] dut__tb__sram_scratchpad_write_data,
  output logic [ADDR_W-1:0] dut__tb__sram_scratchpad_read_address
);

  localparam int          IDX_W = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam logic [15:0] MAX_D = 16'(MAX_DIM);

  typedef enum logic [2:0] {IDLE, LOAD_Q, STREAM_K, WRITE_S, FINISH} state_t;

  state_t              state_q, state_d;
  logic [15:0]         n_q, n_d, d_q, d_d;
  logic [15:0]         i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_W-1:0]   q_base_q, q_base_d, k_base_q, k_base_d;
  logic [ADDR_W-1:0]   nd_q, nd_d, w_addr_q, w_addr_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                dim_err_q, dim_err_d;
  logic [DATA_W-1:0]   qbuf_q [MAX_DIM];
  logic [IDX_W-1:0]    qidx_s;
  logic [ADDR_W-1:0]   rd_addr_s;

  // Read data for address issued at k-1 arrives while k_q == k.
  assign qidx_s = IDX_W'(k_q - 16'd1);

  // Next-state, counters, address generation and accumulation.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    d_d       = d_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    q_base_d  = q_base_q;
    k_base_d  = k_base_q;
    nd_d      = nd_q;
    w_addr_d  = w_addr_q;
    acc_d     = acc_q;
    dim_err_d = dim_err_q;
    rd_addr_s = '0;
    case (state_q)
      IDLE: begin
        if (dut_valid) begin
          n_d      = seq_len;
          d_d      = head_dim;
          i_d      = 16'd0;
          j_d      = 16'd0;
          k_d      = 16'd0;
          q_base_d = '0;
          k_base_d = '0;
          nd_d     = ADDR_W'(32'(seq_len) * 32'(head_dim));
          w_addr_d = ADDR_W'(SCRATCH_BASE);
          acc_d    = '0;
          if (head_dim > MAX_D) begin
            dim_err_d = 1'b1;
            state_d   = FINISH;
          end else begin
            dim_err_d = 1'b0;
            if ((seq_len == 16'd0) || (head_dim == 16'd0)) begin
              state_d = FINISH;
            end else begin
              state_d = LOAD_Q;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_Q: begin
        if (k_q < d_q) begin
          rd_addr_s = q_base_q + ADDR_W'(k_q);
        end else begin
          rd_addr_s = '0;
        end
        if (k_q == d_q) begin
          k_d      = 16'd0;
          j_d      = 16'd0;
          k_base_d = nd_q;
          state_d  = STREAM_K;
        end else begin
          k_d = k_q + 16'd1;
        end
      end
      STREAM_K: begin
        if (k_q < d_q) begin
          rd_addr_s = k_base_q + ADDR_W'(k_q);
        end else begin
          rd_addr_s = '0;
        end
        if (k_q == 16'd0) begin
          acc_d = '0;
        end else begin
          acc_d = acc_q + DATA_W'(qbuf_q[qidx_s] * tb__dut__sram_result_read_data);
        end
        if (k_q == d_q) begin
          k_d     = 16'd0;
          state_d = WRITE_S;
        end else begin
          k_d = k_q + 16'd1;
        end
      end
      WRITE_S: begin
        w_addr_d = w_addr_q + ADDR_W'(1);
        if (j_q < (n_q - 16'd1)) begin
          j_d      = j_q + 16'd1;
          k_base_d = k_base_q + ADDR_W'(d_q);
          state_d  = STREAM_K;
        end else if (i_q < (n_q - 16'd1)) begin
          i_d      = i_q + 16'd1;
          q_base_d = q_base_q + ADDR_W'(d_q);
          state_d  = LOAD_Q;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      n_q       <= 16'd0;
      d_q       <= 16'd0;
      i_q       <= 16'd0;
      j_q       <= 16'd0;
      k_q       <= 16'd0;
      q_base_q  <= '0;
      k_base_q  <= '0;
      nd_q      <= '0;
      w_addr_q  <= '0;
      acc_q     <= '0;
      dim_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      d_q       <= d_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      q_base_q  <= q_base_d;
      k_base_q  <= k_base_d;
      nd_q      <= nd_d;
      w_addr_q  <= w_addr_d;
      acc_q     <= acc_d;
      dim_err_q <= dim_err_d;
    end
  end

  // Q-row buffer capture, one cycle behind each LOAD_Q address.
  always_ff @(posedge clk) begin
    if ((state_q == LOAD_Q) && (k_q != 16'd0)) begin
      qbuf_q[qidx_s] <= tb__dut__sram_result_read_data;
    end
  end

  assign dut_ready                              = (state_q == IDLE);
  assign dim_error                              = dim_err_q;
  assign dut__tb__sram_result_read_address      = rd_addr_s;
  assign dut__tb__sram_scratchpad_write_enable  = (state_q == WRITE_S);
  assign dut__tb__sram_scratchpad_write_address = w_addr_q;
  assign dut__tb__sram_scratchpad_write_data    = acc_q;
  assign dut__tb__sram_scratchpad_read_address  = '0;

endmodule

// File: tb/tb_score_matrix_engine.sv
// Directed + random bench for score_matrix_engine with SRAM models and
// a scoreboard of expected scratchpad writes.
module tb_score_matrix_engine;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int MD = 64;
  localparam int SB = 256;

  logic          clk = 1'b0;
  logic          reset, dut_valid, dut_ready, dim_error;
  logic [15:0]   seq_len, head_dim;
  logic [AW-1:0] rd_addr, waddr, sp_raddr;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] wdata;
  logic          we;

  score_matrix_engine #(.DATA_W(DW), .ADDR_W(AW), .MAX_DIM(MD), .SCRATCH_BASE(SB)) dut (
    .clk(clk), .reset(reset), .dut_valid(dut_valid), .dut_ready(dut_ready),
    .seq_len(seq_len), .head_dim(head_dim), .dim_error(dim_error),
    .dut__tb__sram_result_read_address(rd_addr),
    .tb__dut__sram_result_read_data(rdata),
    .dut__tb__sram_scratchpad_write_enable(we),
    .dut__tb__sram_scratchpad_write_address(waddr),
    .dut__tb__sram_scratchpad_write_data(wdata),
    .dut__tb__sram_scratchpad_read_address(sp_raddr)
  );

  always #5 clk = ~clk;

  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} exp_t;
  exp_t        sb[$];
  logic [31:0] res_mem [0:4095];
  logic [15:0] rd_addr_cap = '0;
  int          n_vec = 0;
  int          n_err = 0;
  int          strobes = 0;
  int          exp_strobes = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result SRAM: data valid one cycle after the address.
  always @(negedge clk) rd_addr_cap = rd_addr;
  always @(posedge clk) begin
    #1;
    rdata = res_mem[rd_addr_cap[11:0]];
  end

  // Scratchpad write monitor against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (we === 1'b1) begin
      strobes++;
      check("strobe_budget", 64'(strobes <= exp_strobes), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("s_addr", 64'(waddr), 64'(e.a));
        check("s_data", 64'(wdata), 64'(e.d));
      end
    end
  end

  task automatic fill_rand(input int n, input int d);
    for (int a = 0; a < 2 * n * d; a++) res_mem[a] = $urandom;
  endtask

  task automatic push_model(input int n, input int d);
    logic [31:0] acc;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        acc = 32'd0;
        for (int k = 0; k < d; k++)
          acc = acc + res_mem[i * d + k] * res_mem[n * d + j * d + k];
        sb.push_back('{a: AW'(SB + i * n + j), d: acc});
      end
  endtask

  task automatic run_job(input int n, input int d, input bit pulse, input bit model);
    int bound;
    int cyc;
    bit skip;
    skip  = (n == 0) || (d == 0) || (d > MD);
    bound = skip ? 3 : n * (d + 2) + n * n * (d + 2) + 3;
    strobes = 0;
    exp_strobes = skip ? 0 : n * n;
    if (model && !skip) push_model(n, d);
    @(posedge clk); #1;
    dut_valid = 1'b1; seq_len = 16'(n); head_dim = 16'(d);
    @(posedge clk); #1;
    dut_valid = 1'b0;
    if (pulse) begin seq_len = 16'd7; head_dim = 16'd1; end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("busy_after_accept", 64'(dut_ready), 64'd0);
      if (pulse) dut_valid = (strobes < n * n) ? 1'(cyc & 1) : 1'b0;
    end while (dut_ready !== 1'b1 && cyc < bound + 10);
    dut_valid = 1'b0;
    check("ready_latency", 64'(cyc <= bound), 64'd1);
    check("strobe_total", 64'(strobes), 64'(exp_strobes));
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("dim_error", 64'(dim_error), 64'(d > MD));
    sb.delete();
  endtask

  initial begin
    int cyc;
    for (int a = 0; a < 4096; a++) res_mem[a] = 32'd0;
    reset = 1'b1; dut_valid = 1'b0; seq_len = 16'd0; head_dim = 16'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(dut_ready), 64'd1);
    check("rst_we", 64'(we), 64'd0);
    check("rst_dim_error", 64'(dim_error), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("sp_rd_addr", 64'(sp_raddr), 64'd0);

    // 2x2 reference matrices with hand-computed results
    res_mem[0] = 32'd1; res_mem[1] = 32'd2; res_mem[2] = 32'd3; res_mem[3] = 32'd4;
    res_mem[4] = 32'd5; res_mem[5] = 32'd6; res_mem[6] = 32'd7; res_mem[7] = 32'd8;
    sb.push_back('{a: AW'(SB + 0), d: 32'd17});
    sb.push_back('{a: AW'(SB + 1), d: 32'd23});
    sb.push_back('{a: AW'(SB + 2), d: 32'd39});
    sb.push_back('{a: AW'(SB + 3), d: 32'd53});
    run_job(2, 2, 1'b0, 1'b0);

    // Wrap-around of product and of sum
    res_mem[0] = 32'h0001_0000; res_mem[1] = 32'h0001_0000;
    sb.push_back('{a: AW'(SB), d: 32'd0});
    run_job(1, 1, 1'b0, 1'b0);
    res_mem[0] = 32'hFFFF_FFFF; res_mem[1] = 32'd1; res_mem[2] = 32'd1; res_mem[3] = 32'd1;
    sb.push_back('{a: AW'(SB), d: 32'd0});
    run_job(1, 2, 1'b0, 1'b0);

    run_job(0, 4, 1'b0, 1'b1);
    run_job(3, 0, 1'b0, 1'b1);
    run_job(2, 65, 1'b0, 1'b1);
    fill_rand(2, 3);
    run_job(2, 3, 1'b0, 1'b1);

    fill_rand(3, 4);
    run_job(3, 4, 1'b1, 1'b1);
    fill_rand(2, MD);
    run_job(2, MD, 1'b0, 1'b1);

    // Mid-job reset after the second strobe
    fill_rand(3, 3);
    push_model(3, 3);
    strobes = 0; exp_strobes = 9;
    @(posedge clk); #1;
    dut_valid = 1'b1; seq_len = 16'd3; head_dim = 16'd3;
    @(posedge clk); #1;
    dut_valid = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (strobes < 2 && cyc < 200);
    check("reach_2nd_strobe", 64'(strobes), 64'd2);
    reset = 1'b1;
    sb.delete();
    exp_strobes = 2;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_ready", 64'(dut_ready), 64'd1);
    check("abort_we", 64'(we), 64'd0);
    check("abort_rd_addr", 64'(rd_addr), 64'd0);
    repeat (40) @(negedge clk);
    check("abort_no_strobes", 64'(strobes), 64'd2);
    res_mem[0] = 32'd1; res_mem[1] = 32'd2; res_mem[2] = 32'd3; res_mem[3] = 32'd4;
    res_mem[4] = 32'd5; res_mem[5] = 32'd6; res_mem[6] = 32'd7; res_mem[7] = 32'd8;
    sb.push_back('{a: AW'(SB + 0), d: 32'd17});
    sb.push_back('{a: AW'(SB + 1), d: 32'd23});
    sb.push_back('{a: AW'(SB + 2), d: 32'd39});
    sb.push_back('{a: AW'(SB + 3), d: 32'd53});
    run_job(2, 2, 1'b0, 1'b0);

    // Random back-to-back jobs
    for (int t = 0; t < 40; t++) begin
      int n;
      int d;
      n = int'($urandom_range(8, 1));
      d = int'($urandom_range(MD, 1));
      fill_rand(n, d);
      run_job(n, d, 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
